// File: rtl/band_mixer_mac.sv
// Multi-band mixer: one signed-sample x unsigned-gain MAC per cycle, then
// round-half-up, saturate and hand the result out over a valid/ready port.
module band_mixer_mac #(
  parameter int DATA_W    = 10,
  parameter int GAIN_W    = 10,
  parameter int FRAC_BITS = 8,
  parameter int N_BANDS   = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BANDS*DATA_W-1:0]    band_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         gain_we,
  input  logic [$clog2(N_BANDS)-1:0]   gain_addr,
  input  logic [GAIN_W-1:0]            gain_wdata,
  output logic signed [DATA_W-1:0]     data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         ovf,
  input  logic                         ovf_clr
);

  localparam int AW     = $clog2(N_BANDS);
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + AW;
  localparam logic [GAIN_W-1:0]        UNITY   = GAIN_W'(2**FRAC_BITS);
  localparam logic signed [ACC_W-1:0]  HALF    = ACC_W'(2**(FRAC_BITS-1));
  localparam logic signed [ACC_W-1:0]  OUT_MAX = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0]  OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, OUTPUT} state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [GAIN_W-1:0]         gain_q [N_BANDS];
  logic [GAIN_W-1:0]         gain_d [N_BANDS];
  logic [GAIN_W-1:0]         snap_q [N_BANDS];
  logic [GAIN_W-1:0]         snap_d [N_BANDS];
  logic signed [DATA_W-1:0]  samp_q [N_BANDS];
  logic signed [DATA_W-1:0]  samp_d [N_BANDS];
  logic signed [DATA_W-1:0]  data_out_q, data_out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      ovf_q, ovf_d;

  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   rnd;
  logic signed [ACC_W-1:0]   shifted;
  logic                      sat_hit;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    gain_d      = gain_q;
    snap_d      = snap_q;
    samp_d      = samp_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    sat_hit     = 1'b0;

    // Gain is zero-extended by one bit so the product treats it as unsigned.
    prod     = PROD_W'(samp_q[k_q]) * PROD_W'($signed({1'b0, snap_q[k_q]}));
    prod_ext = ACC_W'(prod);
    rnd      = acc_q + HALF;
    shifted  = rnd >>> FRAC_BITS;

    // Live gain table update; the snapshot below samples gain_q, so a write
    // landing on the capture cycle only reaches the following frame.
    if (gain_we && ({1'b0, gain_addr} < (AW+1)'(N_BANDS)))
      gain_d[gain_addr] = gain_wdata;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < N_BANDS; i++)
            samp_d[i] = band_in[i*DATA_W +: DATA_W];
          snap_d  = gain_q;
          acc_d   = '0;
          k_d     = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + prod_ext;
        if (k_q == AW'(N_BANDS - 1)) state_d = ROUND;
        else                         k_d     = k_q + AW'(1);
      end
      ROUND: begin
        if (shifted > OUT_MAX) begin
          data_out_d = OUT_MAX[DATA_W-1:0];
          sat_hit    = 1'b1;
        end else if (shifted < OUT_MIN) begin
          data_out_d = OUT_MIN[DATA_W-1:0];
          sat_hit    = 1'b1;
        end else begin
          data_out_d = shifted[DATA_W-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ovf_d = (ovf_q & ~ovf_clr) | sat_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < N_BANDS; i++) begin
        gain_q[i] <= UNITY;
        snap_q[i] <= UNITY;
        samp_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      gain_q      <= gain_d;
      snap_q      <= snap_d;
      samp_q      <= samp_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_band_mixer_mac.sv
// Randomized and directed checks of band_mixer_mac against a plain-arithmetic
// mixing model (sum of sample*gain, round half up, clamp to output range).
module tb_band_mixer_mac;

  localparam int DW = 10;
  localparam int GW = 10;
  localparam int FB = 8;
  localparam int NB = 10;
  localparam int LAT = NB + 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [NB*DW-1:0]       band_in = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   gain_we = 1'b0;
  logic [3:0]             gain_addr = '0;
  logic [GW-1:0]          gain_wdata = '0;
  logic signed [DW-1:0]   data_out;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic                   ovf;
  logic                   ovf_clr = 1'b0;

  band_mixer_mac #(.DATA_W(DW), .GAIN_W(GW), .FRAC_BITS(FB), .N_BANDS(NB)) dut (
    .clk(clk), .reset(reset), .band_in(band_in), .in_valid(in_valid),
    .in_ready(in_ready), .gain_we(gain_we), .gain_addr(gain_addr),
    .gain_wdata(gain_wdata), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int frame_no = 0;

  // Reference state: live gain table, sticky overflow, and next frame samples.
  longint mgain [NB];
  logic   movf;
  longint frame_s [NB];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) mgain[i] = 256;
    movf = 1'b0;
  endtask

  task automatic model_write(input int addr, input longint data);
    if (addr < NB) mgain[addr] = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_gain(input int addr, input int data);
    gain_we    = 1'b1;
    gain_addr  = 4'(addr);
    gain_wdata = GW'(data);
    tick();
    gain_we = 1'b0;
    model_write(addr, longint'(data));
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    movf = 1'b0;
    check_val("ovf_clr", longint'(ovf), 0);
  endtask

  // wcyc: cycle (0 = capture cycle) at which a gain write is issued, -1 none.
  task automatic run_frame(input int hold, input int wcyc, input int waddr, input int wdata);
    longint snap [NB];
    longint acc, res;
    logic   sat;
    int     guard;
    int     cyc;
    logic signed [DW-1:0] held;
    for (int i = 0; i < NB; i++) band_in[i*DW +: DW] = DW'(frame_s[i]);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_val("accept_wait", longint'(guard < 50), 1);
    for (int i = 0; i < NB; i++) snap[i] = mgain[i];
    if (wcyc == 0) begin
      gain_we = 1'b1; gain_addr = 4'(waddr); gain_wdata = GW'(wdata);
    end
    tick();
    in_valid = 1'b0;
    if (gain_we) begin
      gain_we = 1'b0;
      model_write(waddr, longint'(wdata));
    end
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      if (cyc == wcyc) begin
        gain_we = 1'b1; gain_addr = 4'(waddr); gain_wdata = GW'(wdata);
      end
      tick();
      if (gain_we) begin
        gain_we = 1'b0;
        model_write(waddr, longint'(wdata));
      end
      cyc++;
    end

    acc = 0;
    for (int i = 0; i < NB; i++) acc += frame_s[i] * snap[i];
    res = (acc + 128) >>> FB;
    sat = 1'b0;
    if (res > 511)  begin res = 511;  sat = 1'b1; end
    if (res < -512) begin res = -512; sat = 1'b1; end
    if (sat) movf = 1'b1;

    $display("frame %0d: data_out=%0d expected=%0d ovf=%0b latency=%0d hold=%0d",
             frame_no, data_out, res, ovf, cyc, hold);
    frame_no++;
    check_val("latency", cyc, LAT);
    check_val("data_out", longint'(data_out), res);
    check_val("ovf", longint'(ovf), longint'(movf));
    check_val("busy_in_ready", longint'(in_ready), 0);

    held = data_out;
    for (int h = 0; h < hold; h++) begin
      tick();
      check_val("hold_valid", longint'(out_valid), 1);
      check_val("hold_data", longint'(data_out), longint'(held));
      check_val("hold_in_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("drain_valid", longint'(out_valid), 0);
    check_val("drain_in_ready", longint'(in_ready), 1);
    check_val("data_keep", longint'(data_out), longint'(held));
  endtask

  task automatic fill(input longint v);
    for (int i = 0; i < NB; i++) frame_s[i] = v;
  endtask

  initial begin
    int guard;
    logic saw_valid;
    model_reset();
    #1;
    check_val("rst_in_ready", longint'(in_ready), 1);
    check_val("rst_out_valid", longint'(out_valid), 0);
    check_val("rst_data_out", longint'(data_out), 0);
    check_val("rst_ovf", longint'(ovf), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Unity gains, all bands 5.
    fill(5);
    run_frame(0, -1, 0, 0);

    // Doubling gains drive positive saturation; unity with -512 clips low.
    for (int i = 0; i < NB; i++) write_gain(i, 512);
    fill(511);
    run_frame(0, -1, 0, 0);
    clear_ovf();
    for (int i = 0; i < NB; i++) write_gain(i, 256);
    fill(-512);
    run_frame(1, -1, 0, 0);
    clear_ovf();

    // Half gain on band 0 only: rounding of +1.5 and -1.5.
    for (int i = 0; i < NB; i++) write_gain(i, (i == 0) ? 128 : 0);
    fill(7);
    frame_s[0] = 3;
    run_frame(0, -1, 0, 0);
    frame_s[0] = -3;
    run_frame(0, -1, 0, 0);

    // Backpressure for 5 cycles.
    for (int i = 0; i < NB; i++) write_gain(i, 256);
    fill(9);
    run_frame(5, -1, 0, 0);

    // Gain write mid-frame and on the capture cycle, then out-of-range address.
    for (int i = 0; i < NB; i++) frame_s[i] = i + 1;
    run_frame(0, 3, 3, 0);
    run_frame(0, 0, 5, 0);
    run_frame(0, -1, 0, 0);
    write_gain(12, 0);
    run_frame(0, -1, 0, 0);

    // Reset during ACCUM aborts the frame and restores unity gains.
    fill(100);
    for (int i = 0; i < NB; i++) band_in[i*DW +: DW] = DW'(frame_s[i]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check_val("abort_in_ready", longint'(in_ready), 1);
    check_val("abort_out_valid", longint'(out_valid), 0);
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check_val("abort_no_valid", longint'(saw_valid), 0);
    check_val("abort_ovf", longint'(ovf), 0);
    fill(1);
    run_frame(0, -1, 0, 0);

    // Randomized frames, gains, holds and in-flight writes.
    for (int it = 0; it < 40; it++) begin
      int nw;
      int wc;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++)
        write_gain($urandom_range(0, 15), $urandom_range(0, 400));
      for (int i = 0; i < NB; i++) begin
        if (it[0]) frame_s[i] = longint'($urandom_range(0, 255)) - 128;
        else       frame_s[i] = longint'($urandom_range(0, 1023)) - 512;
      end
      wc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 11)) : -1;
      run_frame($urandom_range(0, 3), wc, $urandom_range(0, 15), $urandom_range(0, 400));
      if ($urandom_range(0, 3) == 0) clear_ovf();
    end

    guard = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
